// File: rtl/vend_pkg.sv
// Shared types and constants for the change dispenser.
// Amounts are expressed in 5-unit multiples throughout.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_EJECT  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_FINISH = 3'd4
    } disp_state_e;

    // Coin values in 5-unit multiples
    localparam int unsigned COIN5  = 32'd1;
    localparam int unsigned COIN10 = 32'd2;

    // Larger of two counts; sizes the shared pulse/timeout counter
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request/hopper bundle between the vending controller side (master) and the
// change dispenser (slave). The hopper status and exit-sensor lines belong to
// the master side because they come from the environment, not the dispenser.
interface change_dispenser_if #(
    parameter int unsigned AMT_W = 32'd4
);
    logic             req_valid;
    logic [AMT_W-1:0] req_amt;
    logic             req_ready;
    logic             hop10_empty;
    logic             hop5_empty;
    logic             coin_seen;
    logic             hop10_eject;
    logic             hop5_eject;
    logic             busy;
    logic             done;
    logic             err;
    logic [AMT_W-1:0] owed;

    modport master (
        output req_valid, req_amt, hop10_empty, hop5_empty, coin_seen,
        input  req_ready, hop10_eject, hop5_eject, busy, done, err, owed
    );

    modport slave (
        input  req_valid, req_amt, hop10_empty, hop5_empty, coin_seen,
        output req_ready, hop10_eject, hop5_eject, busy, done, err, owed
    );
endinterface

// File: rtl/disp_timer.sv
// Loadable down-counter shared by the eject-pulse and coin-timeout phases.
// i_start loads i_load; the count then decrements and parks at zero.
// o_expire is high whenever the count is zero.
module disp_timer #(
    parameter int unsigned W = 32'd7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic [W-1:0] i_load,
    output logic         o_expire
);
    logic [W-1:0] r_cnt;

    // Load on start, otherwise count down toward zero and hold there
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {W{1'b0}};
        end else if (i_start) begin
            r_cnt <= i_load;
        end else if (r_cnt != {W{1'b0}}) begin
            r_cnt <= r_cnt - W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_expire = (r_cnt == {W{1'b0}});
endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays a requested amount with greedy 10-first coin choice,
// one eject pulse per coin, waiting for the exit sensor between coins.
// Optional build macro CHANGE_DISP_RETRY_EN: one re-pulse of the same hopper
// after the first coin timeout before giving up.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned AMT_W       = 32'd4,
    parameter int unsigned PULSE_CYC   = 32'd4,
    parameter int unsigned TIMEOUT_CYC = 32'd64
) (
    input  logic              clk,
    input  logic              rst_n,
    change_dispenser_if.slave bus
);
    localparam int unsigned TMR_MAX = max_u(PULSE_CYC, TIMEOUT_CYC);
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 32'd1);
    localparam logic [TMR_W-1:0] PULSE_LOAD   = TMR_W'(PULSE_CYC - 32'd1);
    localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYC - 32'd1);
    localparam logic [AMT_W-1:0] AMT_C5       = AMT_W'(COIN5);
    localparam logic [AMT_W-1:0] AMT_C10      = AMT_W'(COIN10);

    disp_state_e      r_state;
    logic [AMT_W-1:0] r_rem;
    logic             r_sel10;       // coin in flight is a 10
    logic             r_coin_lat;    // exit sensor fired while still ejecting
    logic             r_req_ready;
    logic             r_busy;
    logic             r_hop10_eject;
    logic             r_hop5_eject;
    logic             r_done;
    logic             r_err;
    logic [AMT_W-1:0] r_owed;
`ifdef CHANGE_DISP_RETRY_EN
    logic             r_retry;       // current coin has already been re-pulsed
`endif

    logic             w_pick10;
    logic             w_pick5;
    logic             w_coin_in;
    logic             w_tmr_start;
    logic [TMR_W-1:0] w_tmr_load;
    logic             w_tmr_expire;

    // rem==0 makes both picks false, so SELECT priority falls out naturally
    assign w_pick10  = (r_rem >= AMT_C10) && !bus.hop10_empty;
    assign w_pick5   = (r_rem >= AMT_C5)  && !bus.hop5_empty;
    assign w_coin_in = bus.coin_seen || r_coin_lat;

    disp_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_tmr_start),
        .i_load   (w_tmr_load),
        .o_expire (w_tmr_expire)
    );

    // Timer load requests: pulse length on entry to EJECT, timeout on entry to WAIT
    always_comb begin
        w_tmr_start = 1'b0;
        w_tmr_load  = PULSE_LOAD;
        case (r_state)
            ST_SELECT: begin
                if (w_pick10 || w_pick5) begin
                    w_tmr_start = 1'b1;
                    w_tmr_load  = PULSE_LOAD;
                end else begin
                    w_tmr_start = 1'b0;
                end
            end
            ST_EJECT: begin
                if (w_tmr_expire) begin
                    w_tmr_start = 1'b1;
                    w_tmr_load  = TIMEOUT_LOAD;
                end else begin
                    w_tmr_start = 1'b0;
                end
            end
`ifdef CHANGE_DISP_RETRY_EN
            ST_WAIT: begin
                if (!w_coin_in && w_tmr_expire && !r_retry) begin
                    w_tmr_start = 1'b1;
                    w_tmr_load  = PULSE_LOAD;
                end else begin
                    w_tmr_start = 1'b0;
                end
            end
`endif
            default: begin
                w_tmr_start = 1'b0;
            end
        endcase
    end

    // Payout FSM with all outputs registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_rem         <= {AMT_W{1'b0}};
            r_sel10       <= 1'b0;
            r_coin_lat    <= 1'b0;
            r_req_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_hop10_eject <= 1'b0;
            r_hop5_eject  <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_owed        <= {AMT_W{1'b0}};
`ifdef CHANGE_DISP_RETRY_EN
            r_retry       <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_rem       <= bus.req_amt;
                        r_coin_lat  <= 1'b0;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_SELECT;
`ifdef CHANGE_DISP_RETRY_EN
                        r_retry     <= 1'b0;
`endif
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SELECT: begin
                    if (r_rem == {AMT_W{1'b0}}) begin
                        r_done  <= 1'b1;
                        r_owed  <= r_rem;
                        r_state <= ST_FINISH;
                    end else if (w_pick10) begin
                        r_sel10       <= 1'b1;
                        r_hop10_eject <= 1'b1;
                        r_coin_lat    <= 1'b0;
                        r_state       <= ST_EJECT;
                    end else if (w_pick5) begin
                        r_sel10      <= 1'b0;
                        r_hop5_eject <= 1'b1;
                        r_coin_lat   <= 1'b0;
                        r_state      <= ST_EJECT;
                    end else begin
                        r_err   <= 1'b1;
                        r_owed  <= r_rem;
                        r_state <= ST_FINISH;
                    end
                end
                ST_EJECT: begin
                    // An early sensor hit is held and credited in the first WAIT cycle
                    if (bus.coin_seen) begin
                        r_coin_lat <= 1'b1;
                    end else begin
                        r_coin_lat <= r_coin_lat;
                    end
                    if (w_tmr_expire) begin
                        r_hop10_eject <= 1'b0;
                        r_hop5_eject  <= 1'b0;
                        r_state       <= ST_WAIT;
                    end else begin
                        r_state <= ST_EJECT;
                    end
                end
                ST_WAIT: begin
                    if (w_coin_in) begin
                        r_rem      <= r_rem - (r_sel10 ? AMT_C10 : AMT_C5);
                        r_coin_lat <= 1'b0;
                        r_state    <= ST_SELECT;
`ifdef CHANGE_DISP_RETRY_EN
                        r_retry    <= 1'b0;
                    end else if (w_tmr_expire && !r_retry) begin
                        r_retry       <= 1'b1;
                        r_hop10_eject <= r_sel10;
                        r_hop5_eject  <= !r_sel10;
                        r_state       <= ST_EJECT;
`endif
                    end else if (w_tmr_expire) begin
                        r_err   <= 1'b1;
                        r_owed  <= r_rem;
                        r_state <= ST_FINISH;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_FINISH: begin
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_hop10_eject <= 1'b0;
                    r_hop5_eject  <= 1'b0;
                    r_req_ready   <= 1'b1;
                    r_busy        <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.busy        = r_busy;
    assign bus.hop10_eject = r_hop10_eject;
    assign bus.hop5_eject  = r_hop5_eject;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
    assign bus.owed        = r_owed;
endmodule

// File: doc/change_dispenser.md
# change_dispenser

Pays out change as physical coins from two hoppers (5-unit and 10-unit). It sits downstream of the coin-accepting vending controller, which raises change owed as a request. The block uses a greedy 10-first selection, drives one eject pulse per coin and waits for the hopper exit sensor before the next coin. It reports completion, or an error with the amount still owed.

## Interface
- AMT_W, 4: width of amount fields, in 5-unit multiples (amount 3 = 15 units).
- PULSE_CYC, 4: eject pulse width in cycles, ≥1.
- TIMEOUT_CYC, 64: cycles allowed after eject pulse ends for coin_seen, ≥1.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  change request valid.
- req_amt  in  AMT_W  amount owed, 5-unit multiples.
- req_ready  out  1  high only in IDLE.
- hop10_empty  in  1  level: 10-unit hopper empty.
- hop5_empty  in  1  level: 5-unit hopper empty.
- coin_seen  in  1  one-cycle pulse: a coin passed the exit sensor.
- hop10_eject  out  1  eject pulse to 10-unit hopper.
- hop5_eject  out  1  eject pulse to 5-unit hopper.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse: full amount paid.
- err  out  1  one-cycle pulse: payout aborted.
- owed  out  AMT_W  remaining unpaid amount; valid with done (=0) or err; held until next accept.

## Operation
- States: IDLE, SELECT, EJECT, WAIT, FINISH.
- IDLE: req_ready=1. On req_valid, load rem<=req_amt and go to SELECT.
- SELECT, evaluated in priority order:
  - rem==0: FINISH with done.
  - rem≥2 and !hop10_empty: select 10, go to EJECT.
  - rem≥1 and !hop5_empty: select 5, go to EJECT.
  - Otherwise: FINISH with err.
- Example: rem=3 with hop10 empty pays 5,5,5.
- EJECT: the selected eject output is high for exactly PULSE_CYC cycles, then go to WAIT. Timer resets to 0 on entry to WAIT.
- WAIT: if coin_seen, rem decrements by 2 (10 coin) or 1 (5 coin), then SELECT. Otherwise at timer==TIMEOUT_CYC-1, FINISH with err.
- coin_seen during EJECT is latched and credited at the first WAIT cycle; WAIT then exits immediately.
- coin_seen in IDLE, SELECT or FINISH is ignored.
- At most one coin is credited per eject.
- FINISH: done or err high for one cycle, owed<=rem, then IDLE.
- The two eject outputs are never high simultaneously.
- rem never underflows: 10 is selected only when rem≥2.

## Timing
- Reset values (async, rst_n low): state=IDLE, req_ready=1, busy=0, hop10_eject=0, hop5_eject=0, done=0, err=0, owed=0, rem=0, timer=0.
- Reset mid-payout aborts immediately: eject outputs drop with no done/err.
- Accept at edge T (req_valid && req_ready). SELECT occupies cycle T+1. Eject is high during cycles T+2..T+1+PULSE_CYC.
- Each coin costs 1 + PULSE_CYC + (WAIT cycles until coin_seen, ≥1) cycles.
- req_amt=0: done pulses in cycle T+2. No eject is issued.
- All outputs are registered. Hopper-empty inputs are sampled only in SELECT.

## Configuration
- CHANGE_DISP_RETRY_EN defined: on the first WAIT timeout for a coin, return to EJECT and re-pulse the same hopper once. A second timeout for that coin raises err. The retry flag clears when a coin is credited.
- Undefined: the first timeout raises err. No retry logic is synthesised.

## Structure
- Shared package vend_pkg holds:
  - state enum for IDLE/SELECT/EJECT/WAIT/FINISH;
  - coin value constants COIN5=1 and COIN10=2 in 5-unit multiples.
- One sub-module, disp_timer: a loadable down-counter that provides both the PULSE_CYC and TIMEOUT_CYC counts. It has start/expire ports and width $clog2(max(PULSE_CYC,TIMEOUT_CYC)+1).

## Test plan
- req_amt=3, both hoppers stocked, coin_seen 2 cycles into each WAIT -> hop10_eject once then hop5_eject once, done at end, owed=0.
- req_amt=4, hop10_empty=1 -> four hop5_eject pulses of 4 cycles each, done, owed=0.
- req_amt=2, both hoppers empty -> no eject, err pulse two cycles after accept, owed=2.
- req_amt=2, coin_seen never asserted -> err after PULSE_CYC+TIMEOUT_CYC, owed=2. With CHANGE_DISP_RETRY_EN, two eject pulses are issued before err.
- Spurious coin_seen in IDLE, then req_amt=1 with coin_seen in the 2nd EJECT cycle -> single hop5_eject, credited at first WAIT cycle, done, owed=0.
- rst_n low during EJECT of req_amt=3 -> eject drops asynchronously, no done/err, req_ready=1, next request accepted normally.
